// File: rtl/div_result_bcd.sv
// Result stage of the sequential divider: waits out the divider latency, captures
// quotient/remainder, converts both to packed BCD (shift-add-3) and offers them with valid/ready.
module div_result_bcd #(
    parameter int LAT = 17,
    parameter int QW  = 8,
    parameter int RW  = 4,
    localparam int QD = (QW * 30103) / 100000 + 1,
    localparam int RD = (RW * 30103) / 100000 + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [QW-1:0]     quo,
    input  logic [RW-1:0]     rem,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*QD-1:0]   q_bcd,
    output logic [4*RD-1:0]   r_bcd
);

    localparam int WCW = ($clog2(LAT) < 5) ? 5 : $clog2(LAT);
    localparam int ICW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CONV, S_HOLD} state_t;

    state_t            r_state;
    logic [WCW-1:0]    r_wait_cnt;
    logic [ICW-1:0]    r_iter_cnt;
    logic [QW-1:0]     r_a;
    logic [QW-1:0]     r_b;
    logic [4*QD-1:0]   r_q_acc;
    logic [4*RD-1:0]   r_r_acc;

    logic [4*QD-1:0]   w_q_adj;
    logic [4*RD-1:0]   w_r_adj;
    logic [4*QD-1:0]   w_q_acc_next;
    logic [4*RD-1:0]   w_r_acc_next;

    // Digits are <= 9 before the correction, so the 4-bit add never carries out.
    genvar gi;
    generate
        for (gi = 0; gi < QD; gi++) begin : g_q_digit
            assign w_q_adj[4*gi +: 4] = (r_q_acc[4*gi +: 4] >= 4'd5) ?
                                        r_q_acc[4*gi +: 4] + 4'd3 : r_q_acc[4*gi +: 4];
        end
        for (gi = 0; gi < RD; gi++) begin : g_r_digit
            assign w_r_adj[4*gi +: 4] = (r_r_acc[4*gi +: 4] >= 4'd5) ?
                                        r_r_acc[4*gi +: 4] + 4'd3 : r_r_acc[4*gi +: 4];
        end
    endgenerate

    assign w_q_acc_next = (w_q_adj << 1) | {{(4*QD-1){1'b0}}, r_a[QW-1]};
    assign w_r_acc_next = (w_r_adj << 1) | {{(4*RD-1){1'b0}}, r_b[QW-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_iter_cnt <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_q_acc    <= '0;
            r_r_acc    <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            q_bcd      <= '0;
            r_bcd      <= '0;
        end else if (start) begin
            // A new start always restarts the wait chain; any pending work is dropped.
            r_state    <= S_WAIT;
            r_wait_cnt <= WCW'(LAT - 1);
            busy       <= 1'b1;
            out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_a        <= quo;
                        r_b        <= QW'(rem);
                        r_q_acc    <= '0;
                        r_r_acc    <= '0;
                        r_iter_cnt <= ICW'(QW - 1);
                        r_state    <= S_CONV;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                S_CONV: begin
                    r_a     <= r_a << 1;
                    r_b     <= r_b << 1;
                    r_q_acc <= w_q_acc_next;
                    r_r_acc <= w_r_acc_next;
                    if (r_iter_cnt == '0) begin
                        q_bcd     <= w_q_acc_next;
                        r_bcd     <= w_r_acc_next;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= S_HOLD;
                    end else begin
                        r_iter_cnt <= r_iter_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: models the divider's result timing and checks
// latency, BCD values, handshake, restart and reset behaviour.
module tb_div_result_bcd;

    localparam int LAT = 17;
    localparam int QW  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  quo = 8'h00;
    logic [3:0]  rem = 4'h0;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] q_bcd;
    logic [7:0]  r_bcd;

    int n_checks = 0;
    int n_err    = 0;

    div_result_bcd #(.LAT(LAT), .QW(QW), .RW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .quo       (quo),
        .rem       (rem),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Divider model: garbage on quo/rem except right before edge E_LAT.
    task automatic do_op(input logic [7:0] q, input logic [3:0] r,
                         input logic [11:0] eq, input logic [7:0] er,
                         input logic [11:0] pq, input logic [7:0] pr,
                         input bit rdy_at_start, input bit rdy_during);
        bit busy_ok, valid_quiet, out_stable;
        start = 1'b1; out_ready = rdy_at_start; quo = ~q; rem = ~r;
        tick();
        start = 1'b0; out_ready = rdy_during;
        chk("busy_e0", busy, 1);
        chk("valid_e0", out_valid, 0);
        busy_ok = 1; valid_quiet = 1; out_stable = 1;
        for (int k = 1; k <= LAT + QW; k++) begin
            quo = (k == LAT) ? q : ~q;
            rem = (k == LAT) ? r : ~r;
            tick();
            if (k < LAT + QW) begin
                if (busy !== 1'b1) busy_ok = 0;
                if (out_valid !== 1'b0) valid_quiet = 0;
                if (q_bcd !== pq || r_bcd !== pr) out_stable = 0;
            end
        end
        chk("busy_window", 32'(busy_ok), 1);
        chk("valid_quiet", 32'(valid_quiet), 1);
        chk("out_stable", 32'(out_stable), 1);
        chk("valid_e25", out_valid, 1);
        chk("busy_e25", busy, 0);
        chk("q_bcd", q_bcd, eq);
        chk("r_bcd", r_bcd, er);
        out_ready = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("acc_valid", out_valid, 0);
        chk("acc_busy", busy, 0);
    endtask

    task automatic start_and_run(input int edges, input logic [7:0] q, input logic [3:0] r);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= edges; k++) begin
            quo = (k == LAT) ? q : ~q;
            rem = (k == LAT) ? r : ~r;
            tick();
        end
    endtask

    task automatic check_idle_quiet(input string tag);
        bit quiet;
        quiet = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 0;
        end
        chk(tag, 32'(quiet), 1);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_q", q_bcd, 0);
        chk("rst_r", r_bcd, 0);

        // Basic conversion and latency
        do_op(8'd28, 4'd4, 12'h028, 8'h04, 12'h000, 8'h00, 0, 0);
        accept();
        // Extremes; second one keeps out_ready high outside HOLD
        do_op(8'd255, 4'd0, 12'h255, 8'h00, 12'h028, 8'h04, 0, 0);
        accept();
        do_op(8'd0, 4'd15, 12'h000, 8'h15, 12'h255, 8'h00, 1, 1);
        accept();

        // Backpressure
        do_op(8'd9, 4'd9, 12'h009, 8'h09, 12'h000, 8'h15, 0, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold", {out_valid, q_bcd, r_bcd}, {1'b1, 12'h009, 8'h09});
        end
        accept();

        // Restart three edges into CONV
        start_and_run(LAT + 3, 8'd42, 4'd7);
        chk("mid_conv_busy", busy, 1);
        chk("mid_conv_q", q_bcd, 12'h009);
        do_op(8'd100, 4'd3, 12'h100, 8'h03, 12'h009, 8'h09, 0, 0);

        // start together with out_ready while in HOLD
        do_op(8'd7, 4'd2, 12'h007, 8'h02, 12'h100, 8'h03, 1, 0);
        accept();

        // Reset mid-WAIT
        start_and_run(5, 8'd1, 4'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_all", {busy, out_valid, q_bcd, r_bcd}, 0);
        check_idle_quiet("rstw_quiet");

        // Reset mid-CONV, after a fresh non-zero result
        do_op(8'd28, 4'd4, 12'h028, 8'h04, 12'h000, 8'h00, 0, 0);
        accept();
        start_and_run(LAT + 3, 8'd55, 4'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstc_all", {busy, out_valid, q_bcd, r_bcd}, 0);
        check_idle_quiet("rstc_quiet");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
